// File: rtl/disp_pkg.sv
// Shared sync-phase enumerations and default 1280x720 timing for the display timing generator.
package disp_pkg;

  typedef enum logic [1:0] {
    PH_SYNC  = 2'd0,
    PH_BACK  = 2'd1,
    PH_ACT   = 2'd2,
    PH_FRONT = 2'd3
  } axis_phase_e;

  typedef enum logic [1:0] {
    H_SYNC_S  = 2'd0,
    H_BACK_S  = 2'd1,
    H_ACT_S   = 2'd2,
    H_FRONT_S = 2'd3
  } h_state_e;

  typedef enum logic [1:0] {
    V_SYNC_S  = 2'd0,
    V_BACK_S  = 2'd1,
    V_ACT_S   = 2'd2,
    V_FRONT_S = 2'd3
  } v_state_e;

  localparam int unsigned DEF_H_SYNC   = 40;
  localparam int unsigned DEF_H_BACK   = 220;
  localparam int unsigned DEF_H_ACTIVE = 1280;
  localparam int unsigned DEF_H_FRONT  = 110;
  localparam int unsigned DEF_V_SYNC   = 5;
  localparam int unsigned DEF_V_BACK   = 20;
  localparam int unsigned DEF_V_ACTIVE = 720;
  localparam int unsigned DEF_V_FRONT  = 5;

endpackage

// File: rtl/disp_axis_cnt.sv
// One timing axis: a wrapping position counter and its sync/back/active/front phase FSM.
// Advances only when en_i is high; phase_o is the registered phase of the current count.
module disp_axis_cnt
  import disp_pkg::*;
#(
  parameter int unsigned SYNC   = DEF_H_SYNC,
  parameter int unsigned BACK   = DEF_H_BACK,
  parameter int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned FRONT  = DEF_H_FRONT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  output logic [11:0] cnt_o,
  output logic [1:0]  phase_o
);

  localparam logic [11:0] END_SYNC = 12'(SYNC - 1);
  localparam logic [11:0] END_BACK = 12'(SYNC + BACK - 1);
  localparam logic [11:0] END_ACT  = 12'(SYNC + BACK + ACTIVE - 1);
  localparam logic [11:0] END_TOT  = 12'(SYNC + BACK + ACTIVE + FRONT - 1);

  logic [11:0] cnt_q;
  axis_phase_e state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      state_q <= PH_SYNC;
    end else if (en_i) begin
      cnt_q <= (cnt_q == END_TOT) ? '0 : cnt_q + 12'd1;
      case (state_q)
        PH_SYNC:  if (cnt_q == END_SYNC) state_q <= PH_BACK;
        PH_BACK:  if (cnt_q == END_BACK) state_q <= PH_ACT;
        PH_ACT:   if (cnt_q == END_ACT)  state_q <= PH_FRONT;
        PH_FRONT: if (cnt_q == END_TOT)  state_q <= PH_SYNC;
        default:  state_q <= PH_SYNC;
      endcase
    end
  end

  assign cnt_o   = cnt_q;
  assign phase_o = state_q;

endmodule

// File: rtl/disp_timing.sv
// Display timing generator: horizontal/vertical axis counters, pattern-stage addresses and a
// 2-stage output pipeline. Define DISP_BORDER_EN to overlay a white 1-pixel frame border.
module disp_timing
  import disp_pkg::*;
#(
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BACK   = DEF_H_BACK,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FRONT  = DEF_H_FRONT,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BACK   = DEF_V_BACK,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FRONT  = DEF_V_FRONT,
  parameter logic        SYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [11:0] h_addr,
  output logic [11:0] v_addr,
  input  logic [23:0] data_disp,
  output logic [23:0] rgb_out,
  output logic        de_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam logic [11:0] H_LAST  = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_OFS   = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] V_OFS   = 12'(V_SYNC + V_BACK);

  logic        run_q;
  logic [11:0] h_cnt, v_cnt;
  logic [1:0]  h_ph, v_ph;
  h_state_e    h_state;
  v_state_e    v_state;
  logic        h_wrap, act, hs_raw, vs_raw, fs_raw;
  logic        act1_q, hs1_q, vs1_q, fs1_q;
  logic [23:0] pix;

  // run_q holds the counters at 0 for the first edge after reset release.
  disp_axis_cnt #(.SYNC(H_SYNC), .BACK(H_BACK), .ACTIVE(H_ACTIVE), .FRONT(H_FRONT)) u_h_axis (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (run_q),
    .cnt_o   (h_cnt),
    .phase_o (h_ph)
  );

  assign h_wrap = run_q && (h_cnt == H_LAST);

  disp_axis_cnt #(.SYNC(V_SYNC), .BACK(V_BACK), .ACTIVE(V_ACTIVE), .FRONT(V_FRONT)) u_v_axis (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (h_wrap),
    .cnt_o   (v_cnt),
    .phase_o (v_ph)
  );

  assign h_state = h_state_e'(h_ph);
  assign v_state = v_state_e'(v_ph);
  assign act     = (h_state == H_ACT_S) && (v_state == V_ACT_S);
  assign h_addr  = act ? (h_cnt - H_OFS) : '0;
  assign v_addr  = act ? (v_cnt - V_OFS) : '0;
  assign hs_raw  = (h_state == H_SYNC_S) ? SYNC_POL : ~SYNC_POL;
  assign vs_raw  = (v_state == V_SYNC_S) ? SYNC_POL : ~SYNC_POL;
  assign fs_raw  = act && (h_cnt == H_OFS) && (v_cnt == V_OFS);

`ifdef DISP_BORDER_EN
  logic edge1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge1_q <= 1'b0;
    end else begin
      edge1_q <= act && ((h_addr == '0) || (h_addr == 12'(H_ACTIVE - 1)) ||
                         (v_addr == '0) || (v_addr == 12'(V_ACTIVE - 1)));
    end
  end

  assign pix = edge1_q ? 24'hFFFFFF : data_disp;
`else
  assign pix = data_disp;
`endif

  // Stage 1 lines up with data_disp returning from the pattern stage; stage 2 drives the panel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q       <= 1'b0;
      act1_q      <= 1'b0;
      hs1_q       <= ~SYNC_POL;
      vs1_q       <= ~SYNC_POL;
      fs1_q       <= 1'b0;
      de_out      <= 1'b0;
      hsync_out   <= ~SYNC_POL;
      vsync_out   <= ~SYNC_POL;
      frame_start <= 1'b0;
      rgb_out     <= '0;
    end else begin
      run_q       <= 1'b1;
      act1_q      <= run_q && act;
      hs1_q       <= run_q ? hs_raw : ~SYNC_POL;
      vs1_q       <= run_q ? vs_raw : ~SYNC_POL;
      fs1_q       <= run_q && fs_raw;
      de_out      <= act1_q;
      hsync_out   <= hs1_q;
      vsync_out   <= vs1_q;
      frame_start <= fs1_q;
      rgb_out     <= act1_q ? pix : '0;
    end
  end

endmodule
